dmem_mmio_responder: RTL and testbench

//  Memory-side responder for the pipelined core's M-stage data port; decodes the CPU's address, write strobe, write data and byte enables.

---
 rtl/dmem_mmio_responder_pkg.sv | 25 ++
 rtl/dmem_mmio_responder_if.sv | 10 +
 rtl/dmem_mmio_responder_tx_fifo.sv | 38 +++
 rtl/dmem_mmio_responder.sv | 91 +++++++++
 tb/tb_dmem_mmio_responder.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_mmio_responder_pkg.sv
// dmem_mmio_responder_pkg: address map, MMIO offsets and TX_STATUS layout for the M-stage data responder.
package dmem_mmio_responder_pkg;
   localparam logic [31:0] DMEM_BASE_DEF  = 32'h2000_0000;
   localparam int          DMEM_WORDS_DEF = 1024;
   localparam logic [31:0] MMIO_BASE_DEF  = 32'hFFFF_0000;
   localparam int          FIFO_DEPTH_DEF = 4;
   typedef enum logic [5:0] {
      OFF_GPIO      = 6'h00,
      OFF_TX_DATA   = 6'h04,
      OFF_TX_STATUS = 6'h08,
      OFF_MTIME_LO  = 6'h10,
      OFF_MTIME_HI  = 6'h14,
      OFF_CMP_LO    = 6'h18,
      OFF_CMP_HI    = 6'h1C
   } mmio_off_e;
   localparam int ST_FULL  = 0;
   localparam int ST_EMPTY = 1;
   localparam int ST_CNT   = 2;
   localparam int ST_OVF   = 5;
   function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
      logic [31:0] m;
      for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
      return m;
   endfunction
endpackage

// File: rtl/dmem_mmio_responder_if.sv
// dmem_mmio_responder_if: M-stage data port between the core (master) and the memory responder (slave).
interface dmem_mmio_responder_if;
   logic        MemWriteM;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [3:0]  Byte_Enable;
   logic [31:0] ReadData;
   modport master (output MemWriteM, ALUResult, WriteData, Byte_Enable, input ReadData);
   modport slave  (input MemWriteM, ALUResult, WriteData, Byte_Enable, output ReadData);
endinterface

// File: rtl/dmem_mmio_responder_tx_fifo.sv
// dmem_mmio_responder_tx_fifo: byte FIFO for the TX sink; a push while full is accepted only if a pop frees a slot.
module dmem_mmio_responder_tx_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [7:0]               i_data,
   output logic [7:0]               o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_cnt
);
   localparam int AW = $clog2(DEPTH);
   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [AW:0]   r_cnt;
   logic          w_wr, w_rd;
   assign o_empty = r_cnt == '0;
   assign o_full  = r_cnt == (AW+1)'(DEPTH);
   assign o_cnt   = r_cnt;
   assign o_data  = o_empty ? 8'h00 : r_mem[r_rp];
   assign w_rd    = i_pop && !o_empty;
   assign w_wr    = i_push && (!o_full || w_rd);
   always_ff @(posedge clk)
      if (w_wr) r_mem[r_wp] <= i_data;
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_wr) r_wp <= r_wp + AW'(1);
         if (w_rd) r_rp <= r_rp + AW'(1);
         r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
      end
endmodule

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: decodes the core's M-stage access into byte-lane RAM or the GPIO/timer/TX-FIFO register block.
module dmem_mmio_responder
   import dmem_mmio_responder_pkg::*;
#(
   parameter logic [31:0] DMEM_BASE  = DMEM_BASE_DEF,
   parameter int          DMEM_WORDS = DMEM_WORDS_DEF,
   parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEF,
   parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   n_rst,
   dmem_mmio_responder_if.slave   bus,
   output logic [31:0]            gpio_out,
   output logic                   timer_irq,
   output logic                   tx_valid,
   output logic [7:0]             tx_data,
   input  logic                   tx_ready
);
   localparam int RAW = $clog2(DMEM_WORDS);
   localparam int CW  = $clog2(FIFO_DEPTH) + 1;
   logic [31:0]    r_ram [DMEM_WORDS];
   logic [31:0]    r_gpio;
   logic [63:0]    r_mtime, r_mtimecmp;
   logic           r_irq, r_ovf;
   logic [31:0]    w_ram_off, w_status, w_mmio_rd, w_wd;
   logic [RAW-1:0] w_ram_idx;
   logic [5:0]     w_off;
   logic [3:0]     w_be;
   logic           w_ram_hit, w_mmio_hit, w_mmio_wr, w_push, w_pop, w_full, w_empty, w_clr_ovf;
   logic [CW-1:0]  w_cnt;
   assign w_wd       = bus.WriteData;
   assign w_be       = bus.Byte_Enable;
   // unsigned subtract folds both range bounds into one compare
   assign w_ram_off  = bus.ALUResult - DMEM_BASE;
   assign w_ram_hit  = w_ram_off < 32'(4 * DMEM_WORDS);
   assign w_ram_idx  = w_ram_off[RAW+1:2];
   assign w_mmio_hit = bus.ALUResult[31:6] == MMIO_BASE[31:6];
   assign w_off      = {bus.ALUResult[5:2], 2'b00};
   assign w_mmio_wr  = bus.MemWriteM && w_mmio_hit;
   assign w_push     = w_mmio_wr && w_off == OFF_TX_DATA && w_be[0];
   assign w_clr_ovf  = w_mmio_wr && w_off == OFF_TX_STATUS && w_be[0] && w_wd[ST_OVF];
   assign w_pop      = tx_valid && tx_ready;
   always_comb begin
      w_status             = '0;
      w_status[ST_FULL]    = w_full;
      w_status[ST_EMPTY]   = w_empty;
      w_status[ST_CNT +: 3] = 3'(w_cnt);
      w_status[ST_OVF]     = r_ovf;
   end
   assign w_mmio_rd = w_off == OFF_GPIO      ? r_gpio :
                      w_off == OFF_TX_STATUS ? w_status :
                      w_off == OFF_MTIME_LO  ? r_mtime[31:0] :
                      w_off == OFF_MTIME_HI  ? r_mtime[63:32] :
                      w_off == OFF_CMP_LO    ? r_mtimecmp[31:0] :
                      w_off == OFF_CMP_HI    ? r_mtimecmp[63:32] : 32'h0;
   assign bus.ReadData = w_ram_hit ? r_ram[w_ram_idx] : w_mmio_hit ? w_mmio_rd : 32'h0;
   always_ff @(posedge clk)
      if (bus.MemWriteM && w_ram_hit) r_ram[w_ram_idx] <= be_merge(r_ram[w_ram_idx], w_wd, w_be);
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         r_gpio     <= '0;
         r_mtime    <= '0;
         r_mtimecmp <= '1;
         r_irq      <= 1'b0;
         r_ovf      <= 1'b0;
      end else begin
         if (w_mmio_wr && w_off == OFF_GPIO) r_gpio <= be_merge(r_gpio, w_wd, w_be);
         // a software write to either half of mtime replaces that cycle's increment
         r_mtime <= w_mmio_wr && w_off == OFF_MTIME_LO ? {r_mtime[63:32], be_merge(r_mtime[31:0], w_wd, w_be)} :
                    w_mmio_wr && w_off == OFF_MTIME_HI ? {be_merge(r_mtime[63:32], w_wd, w_be), r_mtime[31:0]} :
                    r_mtime + 64'd1;
         if (w_mmio_wr && w_off == OFF_CMP_LO) r_mtimecmp[31:0]  <= be_merge(r_mtimecmp[31:0], w_wd, w_be);
         if (w_mmio_wr && w_off == OFF_CMP_HI) r_mtimecmp[63:32] <= be_merge(r_mtimecmp[63:32], w_wd, w_be);
         r_irq <= r_mtime >= r_mtimecmp;
         r_ovf <= (w_push && w_full && !w_pop) || (r_ovf && !w_clr_ovf);
      end
   dmem_mmio_responder_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .n_rst   (n_rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_wd[7:0]),
      .o_data  (tx_data),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_cnt   (w_cnt)
   );
   assign tx_valid  = !w_empty;
   assign gpio_out  = r_gpio;
   assign timer_irq = r_irq;
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder: directed scenarios plus random traffic checked against a queue/array reference model.
module tb_dmem_mmio_responder;
   localparam logic [31:0] RB    = 32'h2000_0000;
   localparam logic [31:0] MB    = 32'hFFFF_0000;
   localparam int          WORDS = 1024;
   localparam int          DEPTH = 4;
   logic        clk = 1'b0;
   logic        n_rst = 1'b1;
   logic        tx_ready = 1'b0;
   logic [31:0] gpio_out;
   logic        timer_irq, tx_valid;
   logic [7:0]  tx_data;
   dmem_mmio_responder_if bus();
   dmem_mmio_responder dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .bus       (bus),
      .gpio_out  (gpio_out),
      .timer_irq (timer_irq),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready)
   );
   always #5 clk = ~clk;
   logic [31:0] m_ram [int];
   logic [31:0] m_gpio;
   logic [63:0] m_mtime, m_cmp;
   bit          m_irq, m_ovf;
   logic [7:0]  m_q [$];
   int          n_checks = 0, n_fail = 0, cyc = 0;
   logic [31:0] rd_obs;
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   function automatic bit in_ram(input logic [31:0] a);
      return a >= RB && a < RB + 4 * WORDS;
   endfunction
   function automatic bit in_mmio(input logic [31:0] a);
      return a >= MB && a < MB + 64;
   endfunction
   function automatic int widx(input logic [31:0] a);
      return int'((a - RB) >> 2);
   endfunction
   function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
      return r;
   endfunction
   function automatic logic [31:0] m_read(input logic [31:0] a);
      if (in_ram(a)) return m_ram.exists(widx(a)) ? m_ram[widx(a)] : 32'h0;
      if (!in_mmio(a)) return 32'h0;
      case (a[5:0] & 6'h3C)
         6'h00: return m_gpio;
         6'h08: return {26'd0, m_ovf, 3'(m_q.size()), m_q.size() == 0, m_q.size() == DEPTH};
         6'h10: return m_mtime[31:0];
         6'h14: return m_mtime[63:32];
         6'h18: return m_cmp[31:0];
         6'h1C: return m_cmp[63:32];
         default: return 32'h0;
      endcase
   endfunction
   task automatic model_edge(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be, input bit rdy);
      bit pop, push, mt_wr, irq_n;
      int idx;
      pop   = m_q.size() != 0 && rdy;
      push  = 0;
      mt_wr = 0;
      irq_n = m_mtime >= m_cmp;
      if (we && in_ram(a)) begin
         idx = widx(a);
         if (m_ram.exists(idx)) m_ram[idx] = lanes(m_ram[idx], wd, be);
         else if (be == 4'hF) m_ram[idx] = wd;
      end
      if (we && in_mmio(a))
         case (a[5:0] & 6'h3C)
            6'h00: m_gpio = lanes(m_gpio, wd, be);
            6'h04: push = be[0];
            6'h08: if (be[0] && wd[5]) m_ovf = 0;
            6'h10: begin m_mtime[31:0] = lanes(m_mtime[31:0], wd, be); mt_wr = 1; end
            6'h14: begin m_mtime[63:32] = lanes(m_mtime[63:32], wd, be); mt_wr = 1; end
            6'h18: m_cmp[31:0] = lanes(m_cmp[31:0], wd, be);
            6'h1C: m_cmp[63:32] = lanes(m_cmp[63:32], wd, be);
            default: ;
         endcase
      if (!mt_wr) m_mtime = m_mtime + 64'd1;
      if (pop) void'(m_q.pop_front());
      if (push) begin
         if (m_q.size() < DEPTH) m_q.push_back(wd[7:0]);
         else m_ovf = 1;
      end
      m_irq = irq_n;
   endtask
   // called at a falling edge; returns at the next falling edge after one rising edge
   task automatic step(input bit we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be, input bit rdy);
      bus.MemWriteM   = we;
      bus.ALUResult   = a;
      bus.WriteData   = wd;
      bus.Byte_Enable = be;
      tx_ready        = rdy;
      #1;
      rd_obs = bus.ReadData;
      if (!in_ram(a) || m_ram.exists(widx(a))) chk("rdata", rd_obs, m_read(a));
      chk("gpio", gpio_out, m_gpio);
      chk("irq", timer_irq, m_irq);
      chk("tx_valid", tx_valid, m_q.size() != 0);
      chk("tx_data", tx_data, m_q.size() != 0 ? m_q[0] : 8'h00);
      model_edge(we, a, wd, be, rdy);
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask
   task automatic do_reset();
      bus.MemWriteM   = 1'b0;
      bus.ALUResult   = MB + 32'h10;
      bus.WriteData   = '0;
      bus.Byte_Enable = '0;
      tx_ready        = 1'b0;
      #2 n_rst = 1'b0;
      #1;
      chk("rst_gpio", gpio_out, 0);
      chk("rst_irq", timer_irq, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_mtime", bus.ReadData, 0);
      m_gpio  = '0;
      m_mtime = '0;
      m_cmp   = '1;
      m_irq   = 0;
      m_ovf   = 0;
      m_q.delete();
      @(posedge clk);
      @(negedge clk);
      n_rst = 1'b1;
      cyc   = 0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end
   initial begin
      logic [7:0]  exp4 [4];
      logic [31:0] a;
      int          k;
      @(negedge clk);
      do_reset();
      // RAM lanes, read-during-write, region edges
      step(1, RB, 32'hAABB_CCDD, 4'hF, 0);
      step(1, RB, 32'h0000_1100, 4'h2, 0);
      step(0, RB, 0, 0, 0);
      chk("ram_lane", rd_obs, 32'hAABB_11DD);
      step(1, RB, 32'h5555_5555, 4'hF, 0);
      chk("ram_rdw_old", rd_obs, 32'hAABB_11DD);
      step(0, RB + 32'h1000, 0, 0, 0);
      chk("ram_oob", rd_obs, 0);
      step(1, RB + 4 * (WORDS - 1), 32'hCAFE_F00D, 4'hF, 0);
      step(0, RB + 4 * (WORDS - 1), 0, 0, 0);
      chk("ram_top", rd_obs, 32'hCAFE_F00D);
      step(1, RB - 4, 32'h1234_5678, 4'hF, 0);
      step(0, RB - 4, 0, 0, 0);
      chk("below_ram", rd_obs, 0);
      // timer compare and wrap
      do_reset();
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, MB + 32'h18, 32'd20, 4'hF, 0);
      step(1, MB + 32'h1C, 32'd0, 4'hF, 0);
      while (cyc < 26) begin
         chk("irq_exact", timer_irq, cyc >= 21);
         step(0, 0, 0, 0, 0);
      end
      step(1, MB + 32'h14, 32'hFFFF_FFFF, 4'hF, 0);
      step(1, MB + 32'h10, 32'hFFFF_FFFE, 4'hF, 0);
      step(0, MB + 32'h14, 0, 0, 0);
      chk("mtime_hi_top", rd_obs, 32'hFFFF_FFFF);
      step(0, MB + 32'h10, 0, 0, 0);
      chk("mtime_lo_top", rd_obs, 32'hFFFF_FFFF);
      step(0, MB + 32'h10, 0, 0, 0);
      chk("mtime_wrap_lo", rd_obs, 0);
      step(0, MB + 32'h14, 0, 0, 0);
      chk("mtime_wrap_hi", rd_obs, 0);
      // FIFO fill, overflow, drain
      do_reset();
      for (int b = 8'h41; b <= 8'h45; b++) step(1, MB + 32'h4, 32'(b), 4'h1, 0);
      step(0, MB + 32'h8, 0, 0, 0);
      chk("fifo_full_status", rd_obs, 32'h31);
      for (int i = 0; i < 4; i++) begin
         chk("fifo_drain_order", tx_data, 8'h41 + i);
         step(0, 0, 0, 0, 1);
      end
      step(0, MB + 32'h8, 0, 0, 0);
      chk("fifo_empty_status", rd_obs, 32'h22);
      step(1, MB + 32'h8, 32'h20, 4'hF, 0);
      step(0, MB + 32'h8, 0, 0, 0);
      chk("ovf_clear", rd_obs, 32'h02);
      // push and pop together while full
      for (int b = 8'h61; b <= 8'h64; b++) step(1, MB + 32'h4, 32'(b), 4'h1, 0);
      step(1, MB + 32'h4, 32'h5A, 4'h1, 1);
      step(0, MB + 32'h8, 0, 0, 0);
      chk("full_pushpop_status", rd_obs, 32'h11);
      exp4 = '{8'h62, 8'h63, 8'h64, 8'h5A};
      for (int i = 0; i < 4; i++) begin
         chk("full_pushpop_order", tx_data, exp4[i]);
         step(0, 0, 0, 0, 1);
      end
      chk("full_pushpop_empty", tx_valid, 0);
      // GPIO byte enables, unmapped MMIO
      step(1, MB, 32'h1234_5678, 4'b1001, 0);
      chk("gpio_be", gpio_out, 32'h1200_0078);
      step(1, MB + 32'h3C, 32'hFFFF_FFFF, 4'hF, 0);
      step(0, MB + 32'h3C, 0, 0, 0);
      chk("mmio_unmapped", rd_obs, 0);
      // async reset with traffic pending
      step(1, MB + 32'h18, 0, 4'hF, 0);
      step(1, MB + 32'h1C, 0, 4'hF, 0);
      for (int b = 1; b <= 3; b++) step(1, MB + 32'h4, 32'(b), 4'h1, 0);
      chk("pre_rst_valid", tx_valid, 1);
      chk("pre_rst_irq", timer_irq, 1);
      do_reset();
      step(0, MB + 32'h8, 0, 0, 0);
      chk("post_rst_empty", rd_obs, 32'h02);
      // random traffic
      for (int i = 0; i < 8; i++) step(1, RB + 4 * i, $urandom, 4'hF, 0);
      for (int n = 0; n < 700; n++) begin
         if (n == 350) do_reset();
         k = $urandom_range(0, 9);
         if (k < 4) begin
            k = $urandom_range(0, 8);
            a = k == 8 ? RB + 4 * (WORDS - 1) : RB + 4 * k;
         end else if (k < 9) a = $urandom_range(0, 1) ? MB + 32'h4 : MB + 4 * $urandom_range(0, 15);
         else a = $urandom_range(0, 1) ? RB + 32'h1000 + 4 * $urandom_range(0, 7) : $urandom;
         step($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2) == 0);
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
